// File: rtl/reset_conditioner_pkg.sv
// reset_conditioner_pkg: shared types for the reset conditioner.
// FSM states, reset cause codes and a sizing helper.
package reset_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HOLD,
    WAIT_REL
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_KEY = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_conditioner_sync2.sv
// sync2: two-flop synchronizer for one asynchronous level.
// Both flops load RST_VAL while iRST is low.
module sync2
  import reset_conditioner_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic d,
  output logic q
);

  logic meta;

  // capture the raw level, then re-register it
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_conditioner.sv
// reset_conditioner: debounced key (and optional watchdog) to a clean reset.
// Watchdog built only with RESET_CONDITIONER_WATCHDOG_EN defined.
module reset_conditioner
  import reset_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int PULSE_CYC    = 16,
  parameter int WDT_CYC      = 50000000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iKEY,
  input  logic       iHEARTBEAT,
  output logic       oRST_N,
  output logic       oRST_REQ,
  output logic [1:0] oCAUSE
);

  localparam int CW =
    $clog2(max2(DEBOUNCE_CYC, PULSE_CYC) + 1);
  localparam logic [CW-1:0] DEB_LAST =
    CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] PUL_LAST =
    CW'(PULSE_CYC - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    cause_nxt;
  logic          req_nxt;
  logic          key_s;
  logic          wdt_exp;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_key_sync (
    .iCLK (iCLK),
    .iRST (iRST),
    .d    (iKEY),
    .q    (key_s)
  );

`ifdef RESET_CONDITIONER_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYC + 1);
  localparam logic [WW-1:0] WDT_LAST =
    WW'(WDT_CYC - 1);

  logic          hb_s;
  logic          hb_q;
  logic          hb_edge;
  logic          wdt_run;
  logic [WW-1:0] wdt;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_hb_sync (
    .iCLK (iCLK),
    .iRST (iRST),
    .d    (iHEARTBEAT),
    .q    (hb_s)
  );

  assign hb_edge = hb_s ^ hb_q;
  assign wdt_run = (state == IDLE) ||
                   (state == DEBOUNCE);
  assign wdt_exp = wdt_run && !hb_edge &&
                   (wdt == WDT_LAST);

  // heartbeat edge detect and timeout counter
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      hb_q <= 1'b1;
      wdt  <= '0;
    end else begin
      hb_q <= hb_s;
      if (!wdt_run || hb_edge) begin
        wdt <= '0;
      end else if (wdt != WDT_LAST) begin
        wdt <= wdt + WW'(1);
      end
    end
  end
`else
  logic unused_hb;

  assign unused_hb = iHEARTBEAT;
  assign wdt_exp   = 1'b0;
`endif

  // next state, shared counter and output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = oCAUSE;
    req_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!key_s) begin
          state_nxt = DEBOUNCE;
        end else if (wdt_exp) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_WDT;
          req_nxt   = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (key_s) begin
          state_nxt = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_KEY;
          req_nxt   = 1'b1;
        end else if (wdt_exp) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_WDT;
          req_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (cnt == PUL_LAST) begin
          state_nxt = WAIT_REL;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_REL: begin
        if (!key_s) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = HOLD;
      end
    endcase
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

  // state, counter and registered outputs
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state    <= HOLD;
      cnt      <= '0;
      oRST_N   <= 1'b0;
      oRST_REQ <= 1'b0;
      oCAUSE   <= CAUSE_POR;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      oRST_N   <= (state_nxt != HOLD);
      oRST_REQ <= req_nxt;
      oCAUSE   <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_reset_conditioner.sv
// tb_reset_conditioner: scoreboard bench for reset_conditioner.
// Each completed low pulse of oRST_N is matched to a queued expectation.
module tb_reset_conditioner;

  localparam int DEB = 8;
  localparam int PUL = 4;
  localparam int WDT = 32;

  typedef struct {
    int         width;
    logic [1:0] cause;
    int         reqs;
    int         lat;
  } exp_t;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic       iKEY = 1'b1;
  logic       iHEARTBEAT;
  logic       hb_auto = 1'b0;
  logic       hb_man = 1'b0;
  bit         hb_on = 1'b1;
  logic       oRST_N;
  logic       oRST_REQ;
  logic [1:0] oCAUSE;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   t_mark = 0;
  int   mon_reqs = 0;

  assign iHEARTBEAT = hb_auto ^ hb_man;

  reset_conditioner #(
    .DEBOUNCE_CYC (DEB),
    .PULSE_CYC    (PUL),
    .WDT_CYC      (WDT)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iKEY       (iKEY),
    .iHEARTBEAT (iHEARTBEAT),
    .oRST_N     (oRST_N),
    .oRST_REQ   (oRST_REQ),
    .oCAUSE     (oCAUSE)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic exp_t mk(
    input int         w,
    input logic [1:0] c,
    input int         r,
    input int         l
  );
    exp_t e;
    e.width = w;
    e.cause = c;
    e.reqs  = r;
    e.lat   = l;
    return e;
  endfunction

  task automatic check(
    input string name,
    input int    act,
    input int    req
  );
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d",
               name, act, req);
    end
  endtask

  task automatic check_rst_state();
    check("rst_n_in_reset", int'(oRST_N), 0);
    check("req_in_reset", int'(oRST_REQ), 0);
    check("cause_in_reset", int'(oCAUSE), 0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  initial begin : hb_gen
    int n;
    n = 0;
    forever begin
      @(negedge iCLK);
      if (hb_on) begin
        n++;
        if (n >= 20) begin
          n = 0;
          hb_auto = ~hb_auto;
        end
      end
    end
  end

  initial begin : mon
    logic prev_n;
    int   width;
    int   fall;
    exp_t e;
    prev_n = 1'b0;
    width  = 0;
    fall   = -1;
    forever begin
      @(posedge iCLK);
      #1;
      if (!iRST) begin
        width    = 0;
        mon_reqs = 0;
        fall     = -1;
      end else begin
        if (oRST_REQ) mon_reqs++;
        if (prev_n && !oRST_N) fall = cyc;
        if (!prev_n) width++;
        if (!prev_n && oRST_N) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", width, 0);
          end else begin
            e = exp_q.pop_front();
            check("pulse_width", width, e.width);
            check("cause", int'(oCAUSE),
                  int'(e.cause));
            check("req_pulses", mon_reqs, e.reqs);
            if (e.lat >= 0) begin
              check("latency", fall - t_mark, e.lat);
            end
          end
          width    = 0;
          mon_reqs = 0;
          fall     = -1;
        end
      end
      prev_n = oRST_N;
    end
  end

  initial begin : stim
    wait_cyc(5);
    check_rst_state();
    exp_q.push_back(mk(PUL, 2'b00, 0, -1));
    iRST = 1'b1;
    wait_cyc(20);

    iKEY = 1'b0;
    wait_cyc(5);
    iKEY = 1'b1;
    wait_cyc(2);
    iKEY = 1'b0;
    wait_cyc(6);
    iKEY = 1'b1;
    wait_cyc(30);

    exp_q.push_back(mk(PUL, 2'b01, 1, DEB + 3));
    t_mark = cyc;
    iKEY = 1'b0;
    wait_cyc(100);
    iKEY = 1'b1;
    wait_cyc(5);
    iKEY = 1'b0;
    wait_cyc(20);
    iKEY = 1'b1;
    wait_cyc(20);

    exp_q.push_back(mk(PUL, 2'b01, 1, DEB + 3));
    t_mark = cyc;
    iKEY = 1'b0;
    wait_cyc(30);
    iKEY = 1'b1;
    wait_cyc(20);

    exp_q.push_back(mk(PUL, 2'b00, 0, -1));
    iKEY = 1'b0;
    wait_cyc(12);
    iRST = 1'b0;
    wait_cyc(1);
    check_rst_state();
    iRST = 1'b1;
    wait_cyc(20);
    iKEY = 1'b1;
    wait_cyc(20);

`ifdef RESET_CONDITIONER_WATCHDOG_EN
    hb_on = 1'b0;
    wait_cyc(1);
    exp_q.push_back(mk(PUL, 2'b10, 1, WDT + 3));
    t_mark = cyc;
    hb_man = ~hb_man;
    wait_cyc(60);

    exp_q.push_back(mk(PUL, 2'b01, 1, WDT + 3));
    t_mark = cyc;
    hb_man = ~hb_man;
    wait_cyc(24);
    iKEY = 1'b0;
    wait_cyc(13);
    iKEY = 1'b1;
    wait_cyc(18);
    hb_man = ~hb_man;
    wait_cyc(1);
    hb_on = 1'b1;
`endif

    wait_cyc(1000);
    check("queue_drained", exp_q.size(), 0);
    check("stray_req", mon_reqs, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_conditioner.md
# reset_conditioner

Conditions the board's raw push-button reset (plus an optional watchdog) into one clean, glitch-free, minimum-width active-low reset. The reset is asserted by a registered output and deasserted synchronously to iCLK. oRST_N drives the iRST input of the staged reset sequencer, so every downstream reset stage sees a single well-formed event. oCAUSE records why the last reset happened, for status readback.

## Interface
- DEBOUNCE_CYC, 1000000 — cycles the synchronized key must stay stable to count as a press or release (20 ms at 50 MHz); ≥2
- PULSE_CYC, 16 — cycles oRST_N is held low per reset event; ≥1
- WDT_CYC, 50000000 — heartbeat timeout in cycles (used only with WATCHDOG_EN); ≥2
- iCLK  in  1  system clock
- iRST  in  1  asynchronous, active-low power-on reset; the only asynchronous input
- iKEY  in  1  raw push-button, active-low, asynchronous to iCLK
- iHEARTBEAT  in  1  watchdog heartbeat; any edge counts as a kick; ignored without WATCHDOG_EN
- oRST_N  out  1  conditioned reset, active-low, registered
- oRST_REQ  out  1  one-cycle pulse on entry to HOLD caused by the key or the watchdog
- oCAUSE  out  2  cause of the last reset: 00 power-on, 01 key, 10 watchdog

## Operation
- iKEY and iHEARTBEAT each pass through a 2-flop synchronizer; key_s is the synchronized key.
- One shared counter, cnt. Width is $clog2(max(DEBOUNCE_CYC, PULSE_CYC) + 1). It is zeroed on every state change.
- IDLE:
  - oRST_N=1.
  - key_s=0 → DEBOUNCE.
- DEBOUNCE:
  - oRST_N=1.
  - key_s=1 → IDLE.
  - key_s=0: cnt increments. When cnt reaches DEBOUNCE_CYC-1 with key_s still 0 → HOLD, oCAUSE=01, oRST_REQ pulses.
- HOLD:
  - oRST_N=0.
  - cnt counts to PULSE_CYC-1 → WAIT_REL.
  - Key activity is ignored while in HOLD.
- WAIT_REL:
  - oRST_N=1. No new reset can start in this state.
  - key_s=1 increments cnt; key_s=0 zeroes cnt.
  - cnt reaches DEBOUNCE_CYC-1 → IDLE.
- The press is ignored after HOLD completes: a held key produces exactly one reset pulse and never re-triggers.
- A key bounce shorter than DEBOUNCE_CYC cycles never asserts oRST_N.

## Timing
- While iRST=0:
  - state=HOLD, cnt=0
  - oRST_N=0, oRST_REQ=0, oCAUSE=00
  - synchronizer flops=1
- After iRST rises, oRST_N stays low for exactly PULSE_CYC cycles. This is the power-on stretch, and oRST_REQ does not pulse for it.
- Press latency:
  - First cycle with key_s=0 is cycle 0 in DEBOUNCE.
  - oRST_N falls after the edge ending cycle DEBOUNCE_CYC-1.
  - From the raw pin this is ≤ DEBOUNCE_CYC+3 cycles.
- oRST_N falls and oRST_REQ rises on the same edge.
- oRST_N is low for exactly PULSE_CYC cycles per event.
- oCAUSE updates on entry to HOLD and holds until the next event.
- iRST asserted mid-operation: the block immediately returns to its reset state. oCAUSE becomes 00 and the power-on stretch repeats.

## Configuration
- Macro: RESET_CONDITIONER_WATCHDOG_EN.
- Defined:
  - A second counter, wdt, zeroes on any synchronized iHEARTBEAT edge.
  - wdt increments in IDLE and DEBOUNCE and is held at 0 in HOLD and WAIT_REL.
  - When wdt reaches WDT_CYC-1 → HOLD, oCAUSE=10, oRST_REQ pulses.
  - If key debounce completion and watchdog expiry happen in the same cycle, the key wins: oCAUSE=01.
- Undefined:
  - No wdt counter and no heartbeat synchronizer.
  - iHEARTBEAT is unused.
  - oCAUSE never takes the value 10.

## Structure
- Package reset_conditioner_pkg:
  - state enum {IDLE, DEBOUNCE, HOLD, WAIT_REL}
  - cause localparams CAUSE_POR=2'b00, CAUSE_KEY=2'b01, CAUSE_WDT=2'b10
- Sub-module sync2: a 2-flop synchronizer with a reset value parameter, instantiated per asynchronous input.
- The FSM, counters and output registers live in the top module.

## Test plan
Benches override DEBOUNCE_CYC=8, PULSE_CYC=4, WDT_CYC=32.
- Power-on: hold iRST low 5 cycles, then release → oRST_N low for exactly 4 cycles after release, then 1; oCAUSE=00; oRST_REQ stays 0 throughout.
- Bounce: drive iKEY low for 5 cycles, high for 2, low for 6, then high → oRST_N never falls; state returns to IDLE.
- Clean press held 100 cycles → oRST_N low for exactly 4 cycles ≤11 cycles after the press; one oRST_REQ pulse; oCAUSE=01; no second pulse until the key has been high ≥8 cycles.
- Reset mid-HOLD: press the key, then pulse iRST low in the 2nd HOLD cycle → oCAUSE=00; fresh 4-cycle stretch from iRST release.
- WATCHDOG_EN, no heartbeat → HOLD after 32 idle cycles; oCAUSE=10. Toggling iHEARTBEAT every 20 cycles → no reset over 1000 cycles.
- WATCHDOG_EN, key debounce completes in the same cycle wdt expires → a single HOLD; oCAUSE=01.
